// File: rtl/mem_access_pkg.sv
// mem_access_pkg: RV32I load/store codes, writeback selects and FSM encoding.
package mem_access_pkg;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [1:0] ALUOUT_SEL = 2'd0;
  localparam logic [1:0] DTAMEM_SEL = 2'd1;
  localparam logic [1:0] PC_P_4_SEL = 2'd2;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;
  // size is funct3[1:0]: 0 byte, 1 halfword, 2 word
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
    return (size == 2'b01 && addr[0]) || (size == 2'b10 && addr != 2'b00);
  endfunction
endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: data-memory request/grant/response bus.
interface mem_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/store_align.sv
// store_align: byte enables and lane-replicated store data from size and address offset.
module store_align (
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] rs2,
  output logic [3:0]  be,
  output logic [31:0] wdata
);
  always_comb begin
    be    = size == 2'b00 ? 4'b0001 << addr : size == 2'b01 ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    wdata = size == 2'b00 ? {4{rs2[7:0]}} : size == 2'b01 ? {2{rs2[15:0]}} : rs2;
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage running one bus transaction per load/store and registering the writeback bundle.
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_rs2_data,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_wb_mux,
  input  logic [31:0] ex_pc,
  input  logic [4:0]  ex_rd,
  output logic        stall,
  mem_access_if.master dm,
  output logic        wb_valid,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_data_in,
  output logic [31:0] wb_pc,
  output logic [2:0]  wb_funct3,
  output logic [1:0]  wb_wb_mux,
  output logic [4:0]  wb_rd,
  output logic        misalign
);
  state_t      state, state_nx;
  logic        mem_op, mis, accept, we_q;
  logic [31:0] addr_q, wdata_q, pc_q, wdata_sa;
  logic [3:0]  be_q, be_sa;
  logic [2:0]  f3_q;
  logic [1:0]  mux_q;
  logic [4:0]  rd_q;
  assign mem_op = ex_mem_read | ex_mem_write;
  assign mis    = misaligned(ex_funct3[1:0], ex_alu_out[1:0]);
  assign accept = state == IDLE && ex_valid && mem_op && !mis;
  store_align u_store_align (
    .size  (ex_funct3[1:0]),
    .addr  (ex_alu_out[1:0]),
    .rs2   (ex_rs2_data),
    .be    (be_sa),
    .wdata (wdata_sa)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (accept ? REQ : IDLE) :
               state == REQ  ? (dm.gnt ? RESP : REQ) :
                               (dm.rvalid ? IDLE : RESP);
  always_comb begin
    dm.req = state == REQ;
    dm.we  = state == REQ && we_q;
    stall  = state != IDLE || accept;
  end
  assign dm.addr  = {addr_q[31:2], 2'b00};
  assign dm.be    = be_q;
  assign dm.wdata = wdata_q;
  // Misaligned ops fall into the pass-through path but leave wb_valid low.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {addr_q, wdata_q, pc_q, be_q, f3_q, mux_q, rd_q, we_q} <= '0;
      {wb_valid, wb_alu_out, wb_data_in, wb_pc, wb_funct3, wb_wb_mux, wb_rd, misalign} <= '0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      if (accept) begin
        addr_q  <= ex_alu_out;
        we_q    <= ex_mem_write;
        be_q    <= ex_mem_write ? be_sa : 4'b1111;
        wdata_q <= wdata_sa;
        f3_q    <= ex_funct3;
        mux_q   <= ex_wb_mux;
        pc_q    <= ex_pc;
        rd_q    <= ex_rd;
      end else if (state == IDLE && ex_valid) begin
        wb_valid   <= !mem_op;
        misalign   <= mem_op;
        wb_alu_out <= ex_alu_out;
        wb_data_in <= '0;
        wb_pc      <= ex_pc;
        wb_funct3  <= ex_funct3;
        wb_wb_mux  <= ex_wb_mux;
        wb_rd      <= ex_rd;
      end else if (state == RESP && dm.rvalid) begin
        wb_valid   <= 1'b1;
        wb_alu_out <= addr_q;
        wb_data_in <= we_q ? '0 : dm.rdata >> {addr_q[1:0], 3'b000};
        wb_pc      <= pc_q;
        wb_funct3  <= f3_q;
        wb_wb_mux  <= mux_q;
        wb_rd      <= rd_q;
      end
    end
endmodule
